bcp_implication_queue: RTL and testbench

The implication queue sits directly downstream of the BCP unit-clause detector. It buffers the implied literals the detector produces (variable index plus value) in a FIFO and drains them one per cycle. Each drained literal is applied to the registered `assignment`/`free` vectors, which are fed back to the detector. When an implied value contradicts an existing assignment, the block flags a conflict and flushes all pending implications.

---
 rtl/bcp_implication_queue.sv | 129 ++++++++++++
 tb/tb_bcp_implication_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_implication_queue.sv
// Implication queue behind the BCP unit-clause detector: buffers implied literals
// and applies them one per cycle to the assignment/free state fed back to the detector.
module bcp_implication_queue #(
  parameter int VAR_NUM = 8,
  parameter int IDX_W   = 3,
  parameter int DEPTH   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               imp_valid,
  output logic               imp_ready,
  input  logic [IDX_W-1:0]   imp_var,
  input  logic               imp_val,
  input  logic               drain_en,
  input  logic               load_valid,
  input  logic [VAR_NUM-1:0] load_assignment,
  input  logic [VAR_NUM-1:0] load_free,
  input  logic               clear,
  output logic [VAR_NUM-1:0] assignment,
  output logic [VAR_NUM-1:0] free,
  output logic               apply_valid,
  output logic [IDX_W-1:0]   apply_var,
  output logic               apply_val,
  output logic               conflict,
  output logic [IDX_W-1:0]   conflict_var,
  output logic [IDX_W:0]     count,
  output logic               busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] v;
    logic             x;
  } imp_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CONFLICT} state_t;

  state_t           state, state_nx;
  imp_t             mem [DEPTH];
  imp_t             head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             push, pop, pop_new, pop_conf, wr_en;

  assign imp_ready = (count != FULL) && (state != CONFLICT);
  assign push      = imp_valid && imp_ready;
  assign head      = mem[rd_ptr];
  assign pop       = (count != '0) && drain_en && (state == DRAIN);
  assign pop_new   = pop && free[head.v];
  assign pop_conf  = pop && !free[head.v] && (assignment[head.v] != head.x);
  assign busy      = (count != '0);
  // load/clear and a conflicting pop all swallow a same-cycle push
  assign wr_en     = push && !load_valid && !clear && !pop_conf;

  always_comb begin
    state_nx = state;
    if (load_valid || clear) state_nx = IDLE;
    else begin
      case (state)
        IDLE:     if (push) state_nx = DRAIN;
        DRAIN: begin
          if (pop_conf) state_nx = CONFLICT;
          else if (pop && !push && count == (IDX_W+1)'(1)) state_nx = IDLE;
        end
        CONFLICT: state_nx = CONFLICT;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset && wr_en) mem[wr_ptr] <= '{v: imp_var, x: imp_val};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assignment   <= '0;
      free         <= '1;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      apply_valid  <= 1'b0;
      apply_var    <= '0;
      apply_val    <= 1'b0;
      conflict     <= 1'b0;
      conflict_var <= '0;
    end else begin
      apply_valid <= 1'b0;
      if (load_valid) begin
        assignment <= load_assignment;
        free       <= load_free;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        conflict   <= 1'b0;
      end else if (clear) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        conflict <= 1'b0;
      end else if (pop_conf) begin
        conflict     <= 1'b1;
        conflict_var <= head.v;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        count        <= '0;
      end else begin
        // a pop of an already-assigned, agreeing literal just advances the head
        if (pop_new) begin
          free[head.v]       <= 1'b0;
          assignment[head.v] <= head.x;
          apply_valid        <= 1'b1;
          apply_var          <= head.v;
          apply_val          <= head.x;
        end
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        count <= count + (IDX_W+1)'(push) - (IDX_W+1)'(pop);
      end
    end
  end

endmodule

// File: tb/tb_bcp_implication_queue.sv
// Bench for bcp_implication_queue: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_bcp_implication_queue;

  logic       clk;
  logic       rst_n, iv, ival, de, ld, clr;
  logic [2:0] ivar;
  logic [7:0] la, lf;
  logic       rdy, av, aval, conf, busy;
  logic [7:0] asg, fre;
  logic [2:0] avar, cvar;
  logic [3:0] cnt;

  int errors = 0;
  int checks = 0;

  bcp_implication_queue #(.VAR_NUM(8), .IDX_W(3), .DEPTH(8)) dut (
    .clock(clk), .reset(rst_n),
    .imp_valid(iv), .imp_ready(rdy), .imp_var(ivar), .imp_val(ival),
    .drain_en(de), .load_valid(ld), .load_assignment(la), .load_free(lf),
    .clear(clr), .assignment(asg), .free(fre),
    .apply_valid(av), .apply_var(avar), .apply_val(aval),
    .conflict(conf), .conflict_var(cvar), .count(cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the pending implications are just an ordered queue
  typedef struct {
    logic [2:0] v;
    logic       x;
  } ent_t;

  ent_t       m_q[$];
  logic [7:0] m_asg = 8'h00, m_free = 8'hFF;
  logic       m_av = 1'b0, m_aval = 1'b0, m_conf = 1'b0;
  logic [2:0] m_avar = 3'd0, m_cvar = 3'd0;

  task automatic model_step();
    ent_t h;
    logic acc, killed;
    acc    = iv && (m_q.size() != 8) && !m_conf;
    killed = 1'b0;
    m_av   = 1'b0;
    if (!rst_n) begin
      m_asg = 8'h00; m_free = 8'hFF; m_q.delete();
      m_avar = 3'd0; m_aval = 1'b0; m_conf = 1'b0; m_cvar = 3'd0;
    end else if (ld) begin
      m_asg = la; m_free = lf; m_q.delete(); m_conf = 1'b0;
    end else if (clr) begin
      m_q.delete(); m_conf = 1'b0;
    end else begin
      if (m_q.size() > 0 && de && !m_conf) begin
        h = m_q.pop_front();
        if (m_free[h.v]) begin
          m_free[h.v] = 1'b0; m_asg[h.v] = h.x;
          m_av = 1'b1; m_avar = h.v; m_aval = h.x;
        end else if (m_asg[h.v] != h.x) begin
          m_conf = 1'b1; m_cvar = h.v; m_q.delete(); killed = 1'b1;
        end
      end
      if (acc && !killed) m_q.push_back('{v: ivar, x: ival});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_asg",   32'(asg),  32'(m_asg));
    chk("m_free",  32'(fre),  32'(m_free));
    chk("m_count", 32'(cnt),  32'(m_q.size()));
    chk("m_busy",  32'(busy), 32'(m_q.size() != 0));
    chk("m_rdy",   32'(rdy),  32'((m_q.size() != 8) && !m_conf));
    chk("m_av",    32'(av),   32'(m_av));
    chk("m_avar",  32'(avar), 32'(m_avar));
    chk("m_aval",  32'(aval), 32'(m_aval));
    chk("m_conf",  32'(conf), 32'(m_conf));
    chk("m_cvar",  32'(cvar), 32'(m_cvar));
  endtask

  task automatic idle_in();
    rst_n = 1'b1; iv = 1'b0; ivar = 3'd0; ival = 1'b0;
    ld = 1'b0; clr = 1'b0; la = 8'h00; lf = 8'h00;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int rst_n, iv, ivar, ival, de, ld, la, lf, clr;
    int asg, fre, cnt, av, avar, aval, conf, cvar, rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // reset, single implication, redundant literal, conflict then clear
    tbl[0]  = '{0,1,1,1,1,0,0,0,0, 'h00,'hFF,0,0,0,0,0,0,1};
    tbl[1]  = '{0,1,1,1,1,0,0,0,0, 'h00,'hFF,0,0,0,0,0,0,1};
    tbl[2]  = '{1,1,5,1,1,0,0,0,0, 'h00,'hFF,1,0,0,0,0,0,1};
    tbl[3]  = '{1,0,0,0,1,0,0,0,0, 'h20,'hDF,0,1,5,1,0,0,1};
    tbl[4]  = '{1,0,0,0,1,0,0,0,0, 'h20,'hDF,0,0,5,1,0,0,1};
    tbl[5]  = '{1,1,2,0,1,0,0,0,0, 'h20,'hDF,1,0,5,1,0,0,1};
    tbl[6]  = '{1,1,2,0,1,0,0,0,0, 'h20,'hDB,1,1,2,0,0,0,1};
    tbl[7]  = '{1,0,0,0,1,0,0,0,0, 'h20,'hDB,0,0,2,0,0,0,1};
    tbl[8]  = '{1,1,3,1,1,0,0,0,0, 'h20,'hDB,1,0,2,0,0,0,1};
    tbl[9]  = '{1,1,3,0,1,0,0,0,0, 'h28,'hD3,1,1,3,1,0,0,1};
    tbl[10] = '{1,1,6,1,1,0,0,0,0, 'h28,'hD3,0,0,3,1,1,3,0};
    tbl[11] = '{1,1,6,1,1,0,0,0,0, 'h28,'hD3,0,0,3,1,1,3,0};
    tbl[12] = '{1,1,6,1,1,0,0,0,1, 'h28,'hD3,0,0,3,1,0,3,1};
    tbl[13] = '{1,0,0,0,1,0,0,0,0, 'h28,'hD3,0,0,3,1,0,3,1};

    idle_in();
    de = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      rst_n = 1'(tbl[i].rst_n); iv = 1'(tbl[i].iv); ivar = 3'(tbl[i].ivar);
      ival = 1'(tbl[i].ival); de = 1'(tbl[i].de); ld = 1'(tbl[i].ld);
      la = 8'(tbl[i].la); lf = 8'(tbl[i].lf); clr = 1'(tbl[i].clr);
      tick();
      chk($sformatf("v%0d_asg", i),  32'(asg),  32'(tbl[i].asg));
      chk($sformatf("v%0d_free", i), 32'(fre),  32'(tbl[i].fre));
      chk($sformatf("v%0d_cnt", i),  32'(cnt),  32'(tbl[i].cnt));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].cnt != 0));
      chk($sformatf("v%0d_av", i),   32'(av),   32'(tbl[i].av));
      chk($sformatf("v%0d_avar", i), 32'(avar), 32'(tbl[i].avar));
      chk($sformatf("v%0d_aval", i), 32'(aval), 32'(tbl[i].aval));
      chk($sformatf("v%0d_conf", i), 32'(conf), 32'(tbl[i].conf));
      chk($sformatf("v%0d_cvar", i), 32'(cvar), 32'(tbl[i].cvar));
      chk($sformatf("v%0d_rdy", i),  32'(rdy),  32'(tbl[i].rdy));
    end

    // full FIFO, refused 9th offer, then in-order drain
    do_reset();
    de = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iv = 1'b1; ivar = 3'(i); ival = 1'b1;
      tick();
      chk("fill_cnt", 32'(cnt), 32'(i + 1));
    end
    chk("full_rdy", 32'(rdy), 32'd0);
    iv = 1'b1; ivar = 3'd0; ival = 1'b0;
    tick();
    chk("ninth_cnt", 32'(cnt), 32'd8);
    iv = 1'b0; de = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_av",   32'(av),   32'd1);
      chk("drain_avar", 32'(avar), 32'(i));
      chk("drain_aval", 32'(aval), 32'd1);
      if (i == 0) chk("rdy_after_pop", 32'(rdy), 32'd1);
    end
    chk("full_asg",  32'(asg),  32'h00FF);
    chk("full_free", 32'(fre),  32'h0000);
    chk("full_busy", 32'(busy), 32'd0);

    // load mid-drain, then load and clear together
    for (int r = 0; r < 2; r++) begin
      if (r == 0) do_reset();
      de = 1'b0;
      for (int i = 0; i < 3; i++) begin
        iv = 1'b1; ivar = 3'(i); ival = 1'b1;
        tick();
      end
      chk("ld_pre_cnt", 32'(cnt), 32'd3);
      iv = 1'b1; ivar = 3'd4; ld = 1'b1; la = 8'hA5; lf = 8'h0F;
      clr = (r == 1);
      tick();
      chk("ld_asg",  32'(asg),  32'h00A5);
      chk("ld_free", 32'(fre),  32'h000F);
      chk("ld_cnt",  32'(cnt),  32'd0);
      chk("ld_av",   32'(av),   32'd0);
      idle_in();
      de = 1'b1;
      tick();
      chk("ld_post_av",  32'(av),  32'd0);
      chk("ld_post_cnt", 32'(cnt), 32'd0);
    end

    // random traffic against the model
    do_reset();
    chk_model();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      iv    = ($urandom_range(0, 99) < 70);
      ivar  = 3'($urandom_range(0, 7));
      ival  = 1'($urandom_range(0, 1));
      de    = ($urandom_range(0, 99) < 60);
      ld    = ($urandom_range(0, 59) == 0);
      la    = 8'($urandom);
      lf    = 8'($urandom);
      clr   = ($urandom_range(0, 39) == 0);
      tick();
      chk_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
